mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit of the 5-stage RISC-V pipeline. It sits between the E/M pipeline register and the M/W pipeline register. It takes the memory-stage control and operands, runs one transaction per load/store on a ready/ack data-memory bus, and produces the aligned, extended load result `mmo` for the M/W register. It freezes the pipeline through `stall_m` while a transaction is outstanding, and reports misaligned or illegal accesses and bus timeouts.

## Interface
- `ACK_TIMEOUT`, default 255: maximum BUSY cycles to wait for `dmem_ack`. 0 disables the timeout.
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mm2reg` in 1: the memory-stage instruction is a load.
- `mwmem` in 1: the memory-stage instruction is a store.
- `mfunct3` in 3: load/store width and sign code.
- `malu` in 32: effective byte address.
- `mb` in 32: store data (rs2).
- `mmo` out 32: registered load result, sent to M/W.
- `stall_m` out 1: freeze PC, F/D, D/E, E/M and M/W this cycle.
- `mlsu_err` out 1: misaligned or illegal access, combinational.
- `mbus_err` out 1: one-cycle pulse when a transaction times out.
- `dmem_req` out 1: bus request, registered.
- `dmem_we` out 1: write enable.
- `dmem_addr` out 32: word address, `{malu[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_be` out 4: byte enables.
- `dmem_ack` in 1: transaction complete; read data valid in the same cycle.
- `dmem_rdata` in 32: read word.

## Operation
- FSM has three states: IDLE, BUSY, DONE.
- **Access decode:** an access is requested when `mm2reg|mwmem`.
- **Error conditions** (checked in IDLE):
  - `mm2reg&mwmem` both high;
  - load `mfunct3` is 011, 110 or 111;
  - store `mfunct3` is not 000, 001 or 010;
  - halfword access with `malu[0]=1`;
  - word access with `malu[1:0]≠0`.
- **On error:** `mlsu_err=1`, `stall_m=0`, no bus request, `mmo` unchanged, FSM stays in IDLE.
- **IDLE, valid access:** `stall_m=1`. Next edge: go to BUSY and register `dmem_req=1`, `we`, `addr`, `wdata`, `be`, and the offset/funct3 used for load alignment.
- **BUSY:**
  - `stall_m=1`; all bus outputs held stable.
  - Timeout counter increments each cycle.
  - On `dmem_ack`: for a load, register the aligned/extended data into `mmo`; drop `dmem_req`; go to DONE.
  - If the count reaches `ACK_TIMEOUT` with no ack: drop `req`, pulse `mbus_err`, `mmo` unchanged, go to DONE.
- **DONE:** `stall_m=0`, so the M/W register captures `mmo` at this edge. Next state is IDLE unconditionally. The instruction arriving at that edge is evaluated fresh in IDLE.
- **Store lanes:**
  - SB: `be=4'b0001<<malu[1:0]`, `wdata={4{mb[7:0]}}`.
  - SH: `be` = 0011 or 1100 by `malu[1]`, `wdata={2{mb[15:0]}}`.
  - SW: `be=1111`, `wdata=mb`.
- **Loads:** `be=1111`, `we=0`. Select byte/half by the stored offset. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- **Non-memory instructions:** `stall_m=0`, `mmo` holds its previous value (the M/W `wm2reg=0` masks it).
- **Reset at any time:** FSM to IDLE, counter cleared, all outputs 0.

## Timing
- Reset values: `mmo=0`, `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_wdata=0`, `dmem_be=0`, `mbus_err=0`. `stall_m=0` and `mlsu_err=0` while no access is presented.
- Minimum access length is 3 cycles (IDLE, BUSY with immediate ack, DONE), i.e. 2 stall cycles. Each wait cycle before ack adds one stall cycle.
- `dmem_ack` is sampled only in BUSY; an ack in IDLE or DONE is ignored.
- With `ACK_TIMEOUT=N`, the timeout fires in the Nth BUSY cycle without ack. An ack in that same cycle wins: no error.
- `mmo` changes only at the BUSY→DONE edge of a load.

## Structure
- Shared package `riscv_lsu_pkg` holds:
  - the funct3 constants: `F3_B=000`, `F3_H=001`, `F3_W=010`, `F3_BU=100`, `F3_HU=101`;
  - the state encoding;
  - the lane/byte-enable helper function.
- One sub-module, `lsu_load_align` (combinational): inputs offset, funct3, raw word; output the extended 32-bit value.

## Test plan
- LW at 0x100, ack in first BUSY cycle, `rdata=0xDEADBEEF` -> `stall_m` high exactly 2 cycles; `mmo=0xDEADBEEF` in DONE; `dmem_addr=0x100`, `be=1111`, `we=0`.
- LB at 0x103, `rdata=0x80FF_1234` -> `mmo=0xFFFFFF80`. LBU at the same address -> `mmo=0x00000080`. LHU at 0x102 -> `mmo=0x000080FF`.
- SB at 0x201 with `mb=0x12345678` -> `be=0010`, `wdata=0x78787878`, `we=1`. SH at 0x202 -> `be=1100`, `wdata=0x56785678`. `mmo` unchanged.
- LW at 0x102, and SH at 0x203 -> `mlsu_err=1`, `dmem_req` never rises, `stall_m=0`.
- `ACK_TIMEOUT=4`, no ack -> `req` high 4 cycles, `mbus_err` pulses once, then DONE with `mmo` unchanged. Repeat with ack in cycle 4 -> no error.
- Assert `rst_n` low during BUSY -> `dmem_req`, `stall_m` and `mmo` go to 0 immediately; after release, the next LW completes normally.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// funct3 codes, FSM encoding and store lane helpers.
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] lsu_be(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_wdata(
        input logic [2:0]  f3,
        input logic [31:0] data
    );
        logic [31:0] wd;
        case (f3)
            F3_B:    wd = {4{data[7:0]}};
            F3_H:    wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: picks the addressed byte/half of the
// raw bus word and sign- or zero-extends it to 32 bits.
module lsu_load_align
    import riscv_lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw[7:0];
        case (off)
            2'd1:    byte_v = raw[15:8];
            2'd2:    byte_v = raw[23:16];
            2'd3:    byte_v = raw[31:24];
            default: byte_v = raw[7:0];
        endcase
        half_v = off[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        data = raw;
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h0, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0, half_v};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: one ready/ack bus transaction per load/store,
// stalls the pipeline while outstanding, flags bad accesses and timeouts.
module mem_stage_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [2:0]  mfunct3,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    output logic [31:0] mmo,
    output logic        stall_m,
    output logic        mlsu_err,
    output logic        mbus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [31:0] TO = 32'(ACK_TIMEOUT);

    lsu_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        load_q, load_d;
    logic [31:0] mmo_q, mmo_d;
    logic        bus_err_q, bus_err_d;

    logic        access, bad_f3, misal, err, to_hit;
    logic        stall, lsu_err;
    logic [31:0] ld_data;

    lsu_load_align u_align (
        .off    (off_q),
        .funct3 (f3_q),
        .raw    (dmem_rdata),
        .data   (ld_data)
    );

    always_comb begin
        access = mm2reg | mwmem;
        if (mm2reg)
            bad_f3 = !(mfunct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        else
            bad_f3 = !(mfunct3 inside {F3_B, F3_H, F3_W});
        misal = ((mfunct3[1:0] == 2'b01) & malu[0])
              | ((mfunct3[1:0] == 2'b10) & (|malu[1:0]));
        err    = (mm2reg & mwmem) | bad_f3 | misal;
        to_hit = (TO != 32'd0) && (cnt_q == TO - 32'd1);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        off_d     = off_q;
        f3_d      = f3_q;
        load_d    = load_q;
        mmo_d     = mmo_q;
        bus_err_d = 1'b0;
        stall     = 1'b0;
        lsu_err   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (access && err) begin
                    lsu_err = 1'b1;
                end else if (access) begin
                    stall   = 1'b1;
                    state_d = S_BUSY;
                    cnt_d   = 32'd0;
                    req_d   = 1'b1;
                    we_d    = mwmem;
                    addr_d  = {malu[31:2], 2'b00};
                    wdata_d = lsu_wdata(mfunct3, mb);
                    be_d    = mwmem ? lsu_be(mfunct3, malu[1:0]) : 4'b1111;
                    off_d   = malu[1:0];
                    f3_d    = mfunct3;
                    load_d  = mm2reg;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q + 32'd1;
                // an ack in the final allowed cycle beats the timeout
                if (dmem_ack) begin
                    if (load_q)
                        mmo_d = ld_data;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (to_hit) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            load_q    <= 1'b0;
            mmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
            load_q    <= load_d;
            mmo_q     <= mmo_d;
            bus_err_q <= bus_err_d;
        end
    end

    // decode outputs are forced low while reset is held
    assign stall_m    = rst_n & stall;
    assign mlsu_err   = rst_n & lsu_err;
    assign mbus_err   = bus_err_q;
    assign mmo        = mmo_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus
// randomized loads/stores against an arithmetic reference model.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mm2reg, mwmem;
    logic [2:0]  mfunct3;
    logic [31:0] malu, mb;
    logic [31:0] mmo;
    logic        stall_m, mlsu_err, mbus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_mmo = 32'h0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mm2reg(mm2reg), .mwmem(mwmem), .mfunct3(mfunct3),
        .malu(malu), .mb(mb), .mmo(mmo),
        .stall_m(stall_m), .mlsu_err(mlsu_err), .mbus_err(mbus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_err(input logic ld, st, input logic [2:0] f3,
                                 input logic [31:0] a);
        bit legal;
        if (ld && st) return 1;
        if (ld) legal = (f3 <= 2) || (f3 == 4) || (f3 == 5);
        else    legal = (f3 <= 2);
        if (!legal) return 1;
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3,
                                           input logic [31:0] a, rd);
        logic [31:0] s;
        s = rd >> (8 * (a % 4));
        case (f3)
            0: return (s & 32'h80)   != 0 ? (s & 32'hFF)   | 32'hFFFFFF00 : s & 32'hFF;
            4: return s & 32'hFF;
            1: return (s & 32'h8000) != 0 ? (s & 32'hFFFF) | 32'hFFFF0000 : s & 32'hFFFF;
            5: return s & 32'hFFFF;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] b);
        if (f3 == 0) return (b & 32'hFF) * 32'h01010101;
        if (f3 == 1) return (b & 32'hFFFF) * 32'h00010001;
        return b;
    endfunction

    task automatic nop();
        mm2reg = 1'b0; mwmem = 1'b0; mfunct3 = 3'd0;
        malu = 32'h0; mb = 32'h0; dmem_ack = 1'b0;
    endtask

    task automatic run_access(input logic ld, st, input logic [2:0] f3,
                              input logic [31:0] a, b, input int ack_at,
                              input logic [31:0] rd, input string nm);
        bit e, tmo;
        int k, stalls, lim;
        logic [31:0] ea;
        logic [3:0] ebe;
        logic [31:0] ewd;
        e   = m_err(ld, st, f3, a);
        ea  = a - (a % 4);
        ebe = st ? m_be(f3, a) : 4'b1111;
        ewd = m_wdata(f3, b);
        tmo = (ack_at == 0) || (ack_at > TO);
        lim = tmo ? TO : ack_at;
        @(posedge clk); #1;
        mm2reg = ld; mwmem = st; mfunct3 = f3; malu = a; mb = b;
        dmem_ack = 1'b0; dmem_rdata = rd;
        @(negedge clk);
        n_chk++;
        if (mlsu_err !== e) begin
            n_fail++; $display("FAIL %s lsu_err got %b exp %b", nm, mlsu_err, e);
        end
        n_chk++;
        if (stall_m !== !e) begin
            n_fail++; $display("FAIL %s idle_stall got %b exp %b", nm, stall_m, !e);
        end
        if (e) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_chk++;
            if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin
                n_fail++;
                $display("FAIL %s err_noreq req %b stall %b exp 0 0", nm, dmem_req, stall_m);
            end
            @(posedge clk); #1;
            nop();
            return;
        end
        stalls = 1;
        k = 0;
        while (k < lim) begin
            @(posedge clk); #1;
            k++;
            dmem_ack = (k == ack_at);
            @(negedge clk);
            stalls += stall_m;
            n_chk++;
            if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== ea
                || dmem_be !== ebe || (st && dmem_wdata !== ewd)) begin
                n_fail++;
                $display("FAIL %s bus req %b we %b addr %h be %b wd %h exp 1 %b %h %b %h",
                         nm, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                         st, ea, ebe, ewd);
            end
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (ld && !tmo) exp_mmo = m_load(f3, a, rd);
        @(negedge clk);
        n_chk++;
        if (stall_m !== 1'b0 || dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL %s done stall %b req %b exp 0 0", nm, stall_m, dmem_req);
        end
        n_chk++;
        if (mmo !== exp_mmo) begin
            n_fail++; $display("FAIL %s mmo got %h exp %h", nm, mmo, exp_mmo);
        end
        n_chk++;
        if (mbus_err !== tmo) begin
            n_fail++; $display("FAIL %s bus_err got %b exp %b", nm, mbus_err, tmo);
        end
        n_chk++;
        if (stalls !== lim + 1) begin
            n_fail++; $display("FAIL %s stall_cycles got %0d exp %0d", nm, stalls, lim + 1);
        end
        @(posedge clk); #1;
        nop();
        @(negedge clk);
        n_chk++;
        if (mbus_err !== 1'b0 || stall_m !== 1'b0 || mmo !== exp_mmo) begin
            n_fail++;
            $display("FAIL %s after bus_err %b stall %b mmo %h exp 0 0 %h",
                     nm, mbus_err, stall_m, mmo, exp_mmo);
        end
    endtask

    task automatic test_reset();
        nop();
        dmem_rdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({mmo, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
             mbus_err, stall_m, mlsu_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals mmo %h req %b addr %h be %b exp all 0",
                     mmo, dmem_req, dmem_addr, dmem_be);
        end
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        n_chk++;
        if (dmem_req !== 1'b0 || mmo !== 32'h0) begin
            n_fail++; $display("FAIL idle_ack req %b mmo %h exp 0 0", dmem_req, mmo);
        end
        dmem_ack = 1'b0;
    endtask

    task automatic test_loads();
        run_access(1, 0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF, "lw");
        run_access(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF1234, "lb");
        run_access(1, 0, 3'b100, 32'h103, 0, 2, 32'h80FF1234, "lbu");
        run_access(1, 0, 3'b101, 32'h102, 0, 3, 32'h80FF1234, "lhu");
        run_access(1, 0, 3'b001, 32'h102, 0, 1, 32'h80FF1234, "lh");
    endtask

    task automatic test_stores();
        run_access(0, 1, 3'b000, 32'h201, 32'h12345678, 1, 32'hAAAA5555, "sb");
        run_access(0, 1, 3'b001, 32'h202, 32'h12345678, 2, 32'hAAAA5555, "sh");
        run_access(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 1, 32'hAAAA5555, "sw");
    endtask

    task automatic test_errors();
        run_access(1, 0, 3'b010, 32'h102, 0, 1, 32'h1, "lw_mis");
        run_access(0, 1, 3'b001, 32'h203, 32'h1, 1, 32'h1, "sh_mis");
        run_access(1, 1, 3'b010, 32'h100, 32'h1, 1, 32'h1, "ld_st");
        run_access(1, 0, 3'b011, 32'h100, 0, 1, 32'h1, "ld_f3");
        run_access(0, 1, 3'b100, 32'h100, 0, 1, 32'h1, "st_f3");
    endtask

    task automatic test_timeout();
        run_access(1, 0, 3'b010, 32'h300, 0, 0, 32'h11111111, "lw_tmo");
        run_access(1, 0, 3'b010, 32'h300, 0, 4, 32'h22222222, "lw_ack4");
        run_access(0, 1, 3'b010, 32'h304, 32'h5, 0, 32'h0, "sw_tmo");
        run_access(1, 0, 3'b000, 32'h301, 0, 5, 32'h33333333, "lb_late");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic ld;
            ld = 1'($urandom_range(0, 1));
            run_access(ld, !ld, 3'($urandom_range(0, 7)),
                       32'h400 + 32'($urandom_range(0, 15)), $urandom,
                       $urandom_range(0, 5), $urandom, "rand");
        end
    endtask

    task automatic test_reset_busy();
        @(posedge clk); #1;
        mm2reg = 1'b1; mfunct3 = 3'b010; malu = 32'h500; dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (dmem_req !== 1'b0 || stall_m !== 1'b0 || mmo !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_busy req %b stall %b mmo %h exp 0 0 0", dmem_req, stall_m, mmo);
        end
        nop();
        exp_mmo = 32'h0;
        #1 rst_n = 1'b1;
        run_access(1, 0, 3'b010, 32'h104, 0, 2, 32'h0BADF00D, "lw_post_rst");
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_random();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
